// File: rtl/serial_adder_v.sv
// Bit-serial adder: sums two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
// A single full_adder_v cell does all the arithmetic; the FSM sequences operands through it.

module full_adder_v (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// state | meaning
// IDLE  | waiting for i_start; outputs hold the last result
// RUN   | one operand bit pair consumed per cycle, WIDTH cycles total
// DONE  | result valid, o_done high; i_start here chains the next add
module serial_adder_v #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    full_adder_v u_fa (
        .i_a (a_sr[0]),
        .i_b (b_sr[0]),
        .i_c (carry_q),
        .o_s (fa_s),
        .o_c (fa_co)
    );

    // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
    assign sum_shift = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_nxt = S_RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                last_bit = (cnt == CNT_LAST);
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            o_sum   <= '0;
            o_carry <= 1'b0;
        end else if (accept) begin
            a_sr    <= i_a;
            b_sr    <= i_b;
            carry_q <= i_carry;
            cnt     <= '0;
        end else if (state == S_RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= sum_shift;
            carry_q <= fa_co;
            cnt     <= cnt + CW'(1);
            // Outputs move only once the whole word is complete.
            if (last_bit) begin
                o_sum   <= sum_shift;
                o_carry <= fa_co;
            end
        end
    end

    assign o_busy = (state == S_RUN);
    assign o_done = (state == S_DONE);

endmodule
